// File: rtl/id_ex_register.sv
// ID/EX pipeline register for the RSA decryption ASIP.
// It detects load-use hazards, inserts bubbles, resolves flush/stall priority and counts the bubbles it inserts.
module id_ex_register #(
    parameter int N     = 32,
    parameter int A     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [N-1:0]     id_pc,
    input  logic [N-1:0]     id_rd1,
    input  logic [N-1:0]     id_rd2,
    input  logic [N-1:0]     id_imm,
    input  logic [A-1:0]     id_ra1,
    input  logic [A-1:0]     id_ra2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [A-1:0]     id_wa,
    input  logic             id_reg_write,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_src,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic [2:0]       id_alu_ctrl,
    input  logic             ex_flush,
    input  logic             mem_stall,
    output logic [N-1:0]     ex_pc,
    output logic [N-1:0]     ex_rd1,
    output logic [N-1:0]     ex_rd2,
    output logic [N-1:0]     ex_imm,
    output logic [A-1:0]     ex_ra1,
    output logic [A-1:0]     ex_ra2,
    output logic [A-1:0]     ex_wa,
    output logic             ex_reg_write,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [2:0]       ex_alu_ctrl,
    output logic             ex_valid,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_count
);

    localparam int CTRL_W = 6;

    logic [N-1:0]     pc_reg,   pc_next;
    logic [N-1:0]     rd1_reg,  rd1_next;
    logic [N-1:0]     rd2_reg,  rd2_next;
    logic [N-1:0]     imm_reg,  imm_next;
    logic [A-1:0]     ra1_reg,  ra1_next;
    logic [A-1:0]     ra2_reg,  ra2_next;
    logic [A-1:0]     wa_reg,   wa_next;
    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic [2:0]       alu_reg,  alu_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] cnt_reg,  cnt_next;

    logic [CTRL_W-1:0] ctrl_in;
    logic [CTRL_W-1:0] ctrl_capt;
    logic [1:0]        src_use;
    logic [A-1:0]      src_addr [2];
    logic [1:0]        src_match;
    logic              load_bubble;
    logic              capture;

    // Control bit order: {jump, branch, alu_src, mem_to_reg, mem_write, reg_write}
    assign ctrl_in = {id_jump, id_branch, id_alu_src, id_mem_to_reg, id_mem_write, id_reg_write};

    // An invalid slot must never write, so its control bits are squashed on capture.
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
        assign ctrl_capt[gi] = ctrl_in[gi] & id_valid;
    end

    assign src_use     = {id_use2, id_use1};
    assign src_addr[0] = id_ra1;
    assign src_addr[1] = id_ra2;

    // Register 0 is an ordinary register here, so no zero-address exclusion.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
        assign src_match[gi] = src_use[gi] & (src_addr[gi] == wa_reg);
    end

    assign hazard_stall = valid_reg & ctrl_reg[2] & id_valid & ~ex_flush & (|src_match);

    assign load_bubble = ex_flush | (~mem_stall & hazard_stall);
    assign capture     = ~ex_flush & ~mem_stall & ~hazard_stall;

    always_comb begin
        pc_next    = pc_reg;
        rd1_next   = rd1_reg;
        rd2_next   = rd2_reg;
        imm_next   = imm_reg;
        ra1_next   = ra1_reg;
        ra2_next   = ra2_reg;
        wa_next    = wa_reg;
        ctrl_next  = ctrl_reg;
        alu_next   = alu_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;

        if (load_bubble) begin
            pc_next    = '0;
            rd1_next   = '0;
            rd2_next   = '0;
            imm_next   = '0;
            ra1_next   = '0;
            ra2_next   = '0;
            wa_next    = '0;
            ctrl_next  = '0;
            alu_next   = '0;
            valid_next = 1'b0;
        end else if (capture) begin
            pc_next    = id_pc;
            rd1_next   = id_rd1;
            rd2_next   = id_rd2;
            imm_next   = id_imm;
            ra1_next   = id_ra1;
            ra2_next   = id_ra2;
            wa_next    = id_wa;
            ctrl_next  = ctrl_capt;
            alu_next   = id_alu_ctrl;
            valid_next = id_valid;
        end

        // Only hazard bubbles are counted; flush bubbles are not load-use cost.
        if (~ex_flush && ~mem_stall && hazard_stall && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= '0;
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            imm_reg   <= '0;
            ra1_reg   <= '0;
            ra2_reg   <= '0;
            wa_reg    <= '0;
            ctrl_reg  <= '0;
            alu_reg   <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            pc_reg    <= pc_next;
            rd1_reg   <= rd1_next;
            rd2_reg   <= rd2_next;
            imm_reg   <= imm_next;
            ra1_reg   <= ra1_next;
            ra2_reg   <= ra2_next;
            wa_reg    <= wa_next;
            ctrl_reg  <= ctrl_next;
            alu_reg   <= alu_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign ex_pc         = pc_reg;
    assign ex_rd1        = rd1_reg;
    assign ex_rd2        = rd2_reg;
    assign ex_imm        = imm_reg;
    assign ex_ra1        = ra1_reg;
    assign ex_ra2        = ra2_reg;
    assign ex_wa         = wa_reg;
    assign ex_reg_write  = ctrl_reg[0];
    assign ex_mem_write  = ctrl_reg[1];
    assign ex_mem_to_reg = ctrl_reg[2];
    assign ex_alu_src    = ctrl_reg[3];
    assign ex_branch     = ctrl_reg[4];
    assign ex_jump       = ctrl_reg[5];
    assign ex_alu_ctrl   = alu_reg;
    assign ex_valid      = valid_reg;
    assign bubble_count  = cnt_reg;

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Pipeline register between the decode (ID) stage and the execute (EX) stage of the RSA decryption ASIP.
- Captures the outputs of the decode stage: read-port data, register addresses, control bits, PC, and the zero-extended immediate.
- Detects load-use hazards against the instruction currently in EX, inserts bubbles, and applies the flush/stall priority.
- Keeps a saturating count of inserted bubbles for performance measurement.

Parameters:
- N, 32, datapath width in bits (PC, register data, immediate).
- A, 4, register address width in bits.
- CNT_W, 16, width in bits of the bubble counter.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_pc  in  N  PC of the ID instruction.
- id_rd1, id_rd2  in  N  register-file read data.
- id_imm  in  N  zero-extended immediate from the decode extension unit.
- id_ra1, id_ra2  in  A  source register addresses.
- id_use1, id_use2  in  1  the instruction actually reads ra1 / ra2.
- id_wa  in  A  destination register address.
- id_reg_write, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump  in  1  control bits.
- id_alu_ctrl  in  3  ALU operation.
- ex_flush  in  1  taken branch or jump resolved in EX; kill the younger instruction.
- mem_stall  in  1  downstream memory stall; freeze this register.
- ex_* (one output per id_* input above, except id_use1/id_use2)  out  same width as input  registered copies.
- ex_valid  out  1  EX holds a real instruction.
- hazard_stall  out  1  combinational; tells PC and IF/ID to hold this cycle.
- bubble_count  out  CNT_W  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (async, rst=1): all ex_* outputs = 0, ex_valid = 0, bubble_count = 0. hazard_stall evaluates to 0 because ex_valid = 0.
- Reset asserted mid-operation: discards the in-flight instruction immediately, without waiting for a clock edge.
- hazard_stall = ex_valid & ex_mem_to_reg & id_valid & ~ex_flush & ((id_use1 & id_ra1==ex_wa) | (id_use2 & id_ra2==ex_wa)).
- Register 0 is not special: a match on address 0 still counts as a hazard.
- Per clock edge, the first matching row of this priority list applies:
  1. ex_flush=1: load a bubble (ex_valid=0, all control bits and ex_alu_ctrl = 0; data/address fields = 0). Applies even when mem_stall=1.
  2. mem_stall=1: hold every output. bubble_count unchanged.
  3. hazard_stall=1: load a bubble as in row 1; bubble_count += 1, saturating at all-ones.
  4. Otherwise: capture all id_* fields; ex_valid = id_valid.
- When id_valid=0 and row 4 applies, control bits are captured as 0 regardless of their id_* inputs, so that an invalid slot never writes.
- Latency: one cycle from ID inputs to ex_* outputs. Throughput: one instruction per cycle when no stall, flush, or hazard.
- A load-use hazard costs exactly one bubble. On the following cycle EX holds the bubble (ex_valid=0), so hazard_stall drops and the held ID instruction is captured.
- Back-to-back loads to the same register: each dependent consumer gets its own single bubble.
- Simultaneous mem_stall and hazard: mem_stall wins. hazard_stall stays asserted combinationally, but no bubble is counted until mem_stall deasserts.
- All state is held in flops. The only combinational output is hazard_stall, and it has no path from mem_stall.

Test Plan:
- Reset: assert rst asynchronously between edges while ex_valid=1 with ex_reg_write=1 -> ex_valid=0, ex_reg_write=0, bubble_count=0 immediately, before the next edge.
- Pass-through: id_valid=1, id_pc=0x40, id_imm=0x00000ABC, id_wa=5, id_reg_write=1 -> after one edge, ex_pc=0x40, ex_imm=0xABC, ex_wa=5, ex_reg_write=1, ex_valid=1.
- Load-use: EX holds a load (ex_mem_to_reg=1, ex_wa=3); ID has id_ra2=3, id_use2=1.
  - Expect hazard_stall=1; the next edge gives ex_valid=0 and bubble_count=1.
  - The edge after that captures the held instruction; hazard_stall=0.
- Unused-operand case: the same load-use setup with id_use2=0 and id_use1=1, id_ra1=7 -> hazard_stall=0; no bubble; instruction captured.
- Priority: ex_flush=1, mem_stall=1, and a hazard all in the same cycle -> bubble loaded, bubble_count unchanged, hazard_stall=0.
  - Then mem_stall=1 alone -> all outputs frozen for 3 cycles.
- Counter saturation: with CNT_W=4, force 17 load-use hazards -> bubble_count stops at 0xF and never wraps to 0.
